// File: rtl/mac_fcs_checker.sv
// Receive-side Ethernet FCS checker.
//
// Runs CRC-32 (IEEE 802.3, reflected) over every byte of a framed stream of
// N_LANES bytes per beat, FCS included, and reports at end of frame whether
// the CRC residue matched, whether the length is legal, and the byte count.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clk_en         global enable; when low all state holds, inputs ignored
//   i_valid          beat valid; i_sof / i_eof / i_keep / i_data qualified by it
//   i_keep           byte enables, lane 0 first on the wire, contiguous from lane 0
//   i_data           lane k in bits [8k+7:8k]
//   o_done           one-cycle pulse, frame result valid
//   o_fcs_ok         residue matched and no framing error in the frame
//   o_len_err        frame length outside [MIN_LEN, MAX_LEN]
//   o_proto_err      one-cycle pulse on any framing violation
//   o_frame_len      byte count of the last finished frame
//   o_crc            running CRC in final (complemented) form
module mac_fcs_checker #(
    parameter int unsigned N_LANES  = 8,
    parameter int unsigned W_SYMBOL = 8,
    parameter int unsigned MIN_LEN  = 64,
    parameter int unsigned MAX_LEN  = 1518,
    parameter int unsigned W_LEN    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_clk_en,
    input  logic                         i_valid,
    input  logic                         i_sof,
    input  logic                         i_eof,
    input  logic [N_LANES-1:0]           i_keep,
    input  logic [N_LANES*W_SYMBOL-1:0]  i_data,
    output logic                         o_done,
    output logic                         o_fcs_ok,
    output logic                         o_len_err,
    output logic                         o_proto_err,
    output logic [W_LEN-1:0]             o_frame_len,
    output logic [31:0]                  o_crc
);

    localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]      POLY_REF = 32'hEDB8_8320;
    // Complemented-form CRC of a frame whose appended FCS is correct.
    localparam logic [31:0]      RESIDUE  = 32'h2144_DF1C;
    localparam int unsigned      W_POP    = $clog2(N_LANES + 1);
    localparam logic [W_LEN-1:0] MIN_L    = MIN_LEN[W_LEN-1:0];
    localparam logic [W_LEN-1:0] MAX_L    = MAX_LEN[W_LEN-1:0];

    typedef enum logic [0:0] {StIdle, StFrame} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [N_LANES-1:0] lane_mask(input int unsigned last);
        logic [N_LANES-1:0] m;
        m = '0;
        for (int j = 0; j < N_LANES; j++) begin
            if (j <= int'(last)) m[j] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic len_bad(input logic [W_LEN-1:0] len);
        return (len < MIN_L) || (len > MAX_L);
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [W_LEN-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic               done_q, done_d;
    logic               fcs_ok_q, fcs_ok_d;
    logic               len_err_q, len_err_d;
    logic               proto_q, proto_d;
    logic [W_LEN-1:0]   frame_len_q, frame_len_d;

    logic               start;
    logic [31:0]        seed;
    logic [31:0]        lane_crc [N_LANES];
    logic [31:0]        crc_upd;
    logic               keep_ok;
    logic [W_POP-1:0]   pop;
    logic [W_LEN:0]     cnt_sum;
    logic [W_LEN-1:0]   cnt_n;

    // A sof beat (in either state) or any beat in IDLE starts from the init value.
    assign start = (state_q == StIdle) || i_sof;

    // Keep must be 2^n-1 (n >= 1); partial keep only allowed on the eof beat.
    always_comb begin
        keep_ok = (i_keep != '0)
               && ((i_keep & (i_keep + {{(N_LANES-1){1'b0}}, 1'b1})) == '0)
               && (i_eof || (i_keep == '1));
        pop = '0;
        for (int k = 0; k < N_LANES; k++) begin
            pop = pop + {{(W_POP-1){1'b0}}, i_keep[k]};
        end
        cnt_sum = {1'b0, (start ? {W_LEN{1'b0}} : cnt_q)}
                + {{(W_LEN+1-W_POP){1'b0}}, pop};
        // Saturate rather than wrap; a saturated count is always a length error.
        cnt_n   = cnt_sum[W_LEN] ? {W_LEN{1'b1}} : cnt_sum[W_LEN-1:0];
    end

    // Prefix chain of per-byte updates; the legal keep value selects the tap.
    // An illegal keep leaves the CRC at its seed.
    always_comb begin
        seed        = start ? CRC_INIT : crc_q;
        lane_crc[0] = crc_byte(seed, i_data[7:0]);
        for (int k = 1; k < N_LANES; k++) begin
            lane_crc[k] = crc_byte(lane_crc[k-1], i_data[8*k +: 8]);
        end
        crc_upd = seed;
        for (int k = 0; k < N_LANES; k++) begin
            if (keep_ok && (i_keep == lane_mask(k))) crc_upd = lane_crc[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        done_d      = 1'b0;
        fcs_ok_d    = fcs_ok_q;
        len_err_d   = len_err_q;
        proto_d     = 1'b0;
        frame_len_d = frame_len_q;

        if (i_valid) begin
            if (state_q == StFrame && i_sof) begin
                // Abort the open frame and report it; the beat opens a new frame.
                // A sof+eof beat here only reports the abort, the new frame is dropped.
                done_d      = 1'b1;
                fcs_ok_d    = 1'b0;
                proto_d     = 1'b1;
                frame_len_d = cnt_q;
                len_err_d   = len_bad(cnt_q);
                crc_d       = crc_upd;
                cnt_d       = cnt_n;
                bad_d       = !keep_ok;
                state_d     = i_eof ? StIdle : StFrame;
            end else if (state_q == StIdle && !i_sof) begin
                proto_d = 1'b1;
            end else begin
                crc_d   = crc_upd;
                cnt_d   = cnt_n;
                bad_d   = (start ? 1'b0 : bad_q) | !keep_ok;
                proto_d = !keep_ok;
                if (i_eof) begin
                    done_d      = 1'b1;
                    fcs_ok_d    = (~crc_upd == RESIDUE) && !bad_d;
                    len_err_d   = len_bad(cnt_n);
                    frame_len_d = cnt_n;
                    state_d     = StIdle;
                end else begin
                    state_d = StFrame;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            done_q      <= 1'b0;
            fcs_ok_q    <= 1'b0;
            len_err_q   <= 1'b0;
            proto_q     <= 1'b0;
            frame_len_q <= '0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            done_q      <= done_d;
            fcs_ok_q    <= fcs_ok_d;
            len_err_q   <= len_err_d;
            proto_q     <= proto_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign o_done      = done_q;
    assign o_fcs_ok    = fcs_ok_q;
    assign o_len_err   = len_err_q;
    assign o_proto_err = proto_q;
    assign o_frame_len = frame_len_q;
    assign o_crc       = ~crc_q;

endmodule

// File: tb/tb_mac_fcs_checker.sv
// Directed bench for mac_fcs_checker: one 8-lane and one 4-lane instance.
module tb_mac_fcs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        en8, v8, sof8, eof8;
    logic [7:0]  keep8;
    logic [63:0] d8;
    logic        done8, ok8, lerr8, perr8;
    logic [15:0] len8;
    logic [31:0] crc8;

    logic        en4, v4, sof4, eof4;
    logic [3:0]  keep4;
    logic [31:0] d4;
    logic        done4, ok4, lerr4, perr4;
    logic [15:0] len4;
    logic [31:0] crc4;

    mac_fcs_checker #(.N_LANES(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_clk_en(en8), .i_valid(v8), .i_sof(sof8),
        .i_eof(eof8), .i_keep(keep8), .i_data(d8), .o_done(done8), .o_fcs_ok(ok8),
        .o_len_err(lerr8), .o_proto_err(perr8), .o_frame_len(len8), .o_crc(crc8)
    );

    mac_fcs_checker #(.N_LANES(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_clk_en(en4), .i_valid(v4), .i_sof(sof4),
        .i_eof(eof4), .i_keep(keep4), .i_data(d4), .o_done(done4), .o_fcs_ok(ok4),
        .o_len_err(lerr4), .o_proto_err(perr4), .o_frame_len(len4), .o_crc(crc4)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] fb [0:2047];

    // Log of 4-lane frame results, sampled one edge after they appear.
    int          n_done4 = 0;
    logic        q_ok4   [$];
    logic        q_perr4 [$];
    logic [15:0] q_len4  [$];
    always @(posedge clk) begin
        if (!rst && done4) begin
            n_done4 <= n_done4 + 1;
            q_ok4.push_back(ok4);
            q_perr4.push_back(perr4);
            q_len4.push_back(len4);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC-32 over fb[0..n-1], final (complemented) form.
    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        logic        b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                b = fb[i][j] ^ c[0];
                c = c >> 1;
                if (b) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    // Payload of n-4 bytes followed by its FCS, least significant byte first.
    task automatic build_frame(input int n);
        logic [31:0] c;
        for (int i = 0; i < n - 4; i++) fb[i] = 8'((i * 7 + 3) & 255);
        c = crc_ref(n - 4);
        for (int k = 0; k < 4; k++) fb[n - 4 + k] = c[8*k +: 8];
    endtask

    function automatic logic [31:0] pack4(input int pos, input int k);
        logic [31:0] d;
        d = '0;
        for (int j = 0; j < k; j++) d[8*j +: 8] = fb[pos + j];
        return d;
    endfunction

    function automatic logic [63:0] pack8(input int pos, input int k);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < k; j++) d[8*j +: 8] = fb[pos + j];
        return d;
    endfunction

    function automatic logic [3:0] mask4(input int k);
        logic [3:0] m;
        m = '0;
        for (int j = 0; j < k; j++) m[j] = 1'b1;
        return m;
    endfunction

    task automatic set8(input logic v, input logic s, input logic e, input logic [7:0] k,
                        input logic [63:0] d);
        en8 = 1'b1; v8 = v; sof8 = s; eof8 = e; keep8 = k; d8 = d;
    endtask

    task automatic set4(input logic v, input logic s, input logic e, input logic [3:0] k,
                        input logic [31:0] d);
        en4 = 1'b1; v4 = v; sof4 = s; eof4 = e; keep4 = k; d4 = d;
    endtask

    // Sends fb[0..n-1]; after beat gap_after inserts gap_len idle cycles, either
    // with i_valid low or with i_clk_en low while garbage sof/eof beats are shown.
    // Returns at the negedge following the eof beat.
    task automatic send4(input int n, input int gap_after, input int gap_len,
                         input bit gap_clken);
        int pos  = 0;
        int beat = 0;
        int k;
        while (pos < n) begin
            k = (n - pos >= 4) ? 4 : n - pos;
            @(negedge clk);
            set4(1'b1, beat == 0, pos + k >= n, mask4(k), pack4(pos, k));
            pos += k;
            beat++;
            if (beat == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (gap_clken) begin
                        set4(1'b1, 1'b1, 1'b1, 4'hF, $urandom);
                        en4 = 1'b0;
                    end else begin
                        set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
                    end
                end
            end
        end
        @(negedge clk);
        set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string s;
        int    mark;

        rst = 1'b1;
        set8(1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_crc8", crc8, 32'h0);
        check("rst_crc4", crc4, 32'h0);
        check("rst_done8", {31'h0, done8}, 32'h0);
        check("rst_ok8", {31'h0, ok8}, 32'h0);
        check("rst_lerr8", {31'h0, lerr8}, 32'h0);
        check("rst_perr8", {31'h0, perr8}, 32'h0);
        check("rst_len8", {16'h0, len8}, 32'h0);
        rst = 1'b0;

        // 1: "123456789" + FCS on 8 lanes.
        s = "123456789";
        for (int i = 0; i < 9; i++) fb[i] = s[i];
        fb[9] = 8'h26; fb[10] = 8'h39; fb[11] = 8'hF4; fb[12] = 8'hCB;
        @(negedge clk); set8(1'b1, 1'b1, 1'b0, 8'hFF, pack8(0, 8));
        @(negedge clk);
        check("t1_crc_beat1", crc8, crc_ref(8));
        set8(1'b1, 1'b0, 1'b1, 8'h1F, pack8(8, 5));
        @(negedge clk); set8(1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        check("t1_done", {31'h0, done8}, 32'h1);
        check("t1_ok", {31'h0, ok8}, 32'h1);
        check("t1_len", {16'h0, len8}, 32'd13);
        check("t1_lerr", {31'h0, lerr8}, 32'h1);
        check("t1_perr", {31'h0, perr8}, 32'h0);
        check("t1_crc_done", crc8, 32'h2144DF1C);
        @(negedge clk);
        check("t1_done_pulse", {31'h0, done8}, 32'h0);
        check("t1_crc_hold", crc8, 32'h2144DF1C);

        // 2: corrupted last FCS byte.
        fb[12] = 8'hCA;
        @(negedge clk); set8(1'b1, 1'b1, 1'b0, 8'hFF, pack8(0, 8));
        @(negedge clk); set8(1'b1, 1'b0, 1'b1, 8'h1F, pack8(8, 5));
        @(negedge clk); set8(1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        check("t2_done", {31'h0, done8}, 32'h1);
        check("t2_ok", {31'h0, ok8}, 32'h0);
        check("t2_len", {16'h0, len8}, 32'd13);

        // 3: 64-byte frame on 4 lanes with a valid gap, then 1519 bytes.
        build_frame(64);
        send4(64, 5, 3, 1'b0);
        check("t3_done", {31'h0, done4}, 32'h1);
        check("t3_ok", {31'h0, ok4}, 32'h1);
        check("t3_lerr", {31'h0, lerr4}, 32'h0);
        check("t3_len", {16'h0, len4}, 32'd64);
        check("t3_crc", crc4, 32'h2144DF1C);
        build_frame(1519);
        send4(1519, 0, 0, 1'b0);
        check("t3b_ok", {31'h0, ok4}, 32'h1);
        check("t3b_lerr", {31'h0, lerr4}, 32'h1);
        check("t3b_len", {16'h0, len4}, 32'd1519);

        // 4: single-beat frames, legal and illegal keep.
        @(negedge clk); set4(1'b1, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF);
        @(negedge clk); set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        check("t4_done", {31'h0, done4}, 32'h1);
        check("t4_len", {16'h0, len4}, 32'd4);
        check("t4_lerr", {31'h0, lerr4}, 32'h1);
        check("t4_perr", {31'h0, perr4}, 32'h0);
        @(negedge clk); set4(1'b1, 1'b1, 1'b1, 4'h5, 32'h12345678);
        @(negedge clk); set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        check("t4b_done", {31'h0, done4}, 32'h1);
        check("t4b_ok", {31'h0, ok4}, 32'h0);
        check("t4b_perr", {31'h0, perr4}, 32'h1);
        check("t4b_len", {16'h0, len4}, 32'd2);
        @(negedge clk);
        check("t4b_perr_pulse", {31'h0, perr4}, 32'h0);

        // 5: beat in IDLE without sof, then sof inside an open frame.
        repeat (2) @(negedge clk);
        mark = n_done4;
        set4(1'b1, 1'b0, 1'b0, 4'hF, 32'hA5A5A5A5);
        @(negedge clk); set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        check("t5_idle_perr", {31'h0, perr4}, 32'h1);
        check("t5_idle_done", {31'h0, done4}, 32'h0);
        repeat (2) @(negedge clk);
        check("t5_idle_ndone", n_done4, mark);
        check("t5_idle_perr_pulse", {31'h0, perr4}, 32'h0);
        build_frame(64);
        mark = q_ok4.size();
        @(negedge clk); set4(1'b1, 1'b1, 1'b0, 4'hF, 32'h11111111);
        @(negedge clk); set4(1'b1, 1'b0, 1'b0, 4'hF, 32'h22222222);
        send4(64, 0, 0, 1'b0);
        check("t5_new_done", {31'h0, done4}, 32'h1);
        check("t5_new_ok", {31'h0, ok4}, 32'h1);
        check("t5_new_len", {16'h0, len4}, 32'd64);
        check("t5_new_perr", {31'h0, perr4}, 32'h0);
        repeat (2) @(negedge clk);
        check("t5_nresults", q_ok4.size(), mark + 2);
        check("t5_abort_ok", {31'h0, q_ok4[mark]}, 32'h0);
        check("t5_abort_perr", {31'h0, q_perr4[mark]}, 32'h1);
        check("t5_abort_len", {16'h0, q_len4[mark]}, 32'd8);

        // 6: reset mid-frame, then a clean frame; then clk_en low mid-frame.
        @(negedge clk); set4(1'b1, 1'b1, 1'b0, 4'hF, pack4(0, 4));
        @(negedge clk); set4(1'b1, 1'b0, 1'b0, 4'hF, pack4(4, 4));
        @(negedge clk); set4(1'b1, 1'b0, 1'b0, 4'hF, pack4(8, 4));
        @(negedge clk); set4(1'b0, 1'b0, 1'b0, 4'h0, 32'h0); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("t6_rst_crc", crc4, 32'h0);
        check("t6_rst_done", {31'h0, done4}, 32'h0);
        mark = n_done4;
        send4(64, 0, 0, 1'b0);
        check("t6_ok", {31'h0, ok4}, 32'h1);
        check("t6_len", {16'h0, len4}, 32'd64);
        repeat (2) @(negedge clk);
        check("t6_ndone", n_done4, mark + 1);
        mark = n_done4;
        send4(64, 5, 4, 1'b1);
        check("t6_en_done", {31'h0, done4}, 32'h1);
        check("t6_en_ok", {31'h0, ok4}, 32'h1);
        check("t6_en_lerr", {31'h0, lerr4}, 32'h0);
        check("t6_en_len", {16'h0, len4}, 32'd64);
        repeat (2) @(negedge clk);
        check("t6_en_ndone", n_done4, mark + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
